mc_controller_ws: RTL and testbench

- Next-generation multicycle ARM control unit.
- Contains the main-FSM decoder, the ALU decoder and the condition logic, with a flags register.
- Adds AHB-style memory wait states: the FSM holds in any memory state until MemReady is high.
- Parametrised ALU opcode width and optional BL (branch-with-link).
- Drives the existing multicycle datapath and the bus-master shim.

---
 rtl/mc_ctrl_pkg.sv | 69 ++++++
 rtl/mc_condlogic.sv | 66 ++++++
 rtl/mc_controller_ws.sv | 210 +++++++++++++++++++++
 tb/tb_mc_controller_ws.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM controller with bus wait states.
// Holds the FSM state enum, ALU operation codes, mux-select encodings, cond codes and DP cmd codes.
// No logic lives here; the controller and condition logic import it.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWR,
      S_MEMWB,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BRANCH
   } state_t;

   // ALU operations (3 bits internally, truncated to the configured width)
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_ORR = 3'd3;
   localparam logic [2:0] ALU_EOR = 3'd4;

   // Result mux selects
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] RES_PC        = 2'b11;

   // ALU B-operand selects
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Instruction classes (Instr[27:26])
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // Condition codes (Instr[31:28])
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // Data-processing cmd field (Instr[24:21])
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_TST = 4'b1000;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/mc_condlogic.sv
// Condition logic: NZCV flags register, CondEx evaluation and gating of architectural writes.
// Latency: CondEx and write gating are combinational; flags update on the clock edge ending the state.
// No backpressure of its own; the caller only raises flagw in execute states, never in wait states.
module mc_condlogic
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] aluflags,
   input  logic [1:0] flagw,
   input  logic       regw,
   input  logic       memw,
   input  logic       pcs,
   input  logic       fetch_done,
   input  logic       pcwb,
   output logic       pcwrite,
   output logic       regwrite,
   output logic       memwrite
);

   logic [3:0] flags;
   logic       n, z, c, v;
   logic       condex;

   assign {n, z, c, v} = flags;

   // Evaluate the instruction's condition against the registered (old) flags
   always_comb begin
      condex = 1'b0;
      case (cond)
         COND_EQ: condex = z;
         COND_NE: condex = ~z;
         COND_CS: condex = c;
         COND_CC: condex = ~c;
         COND_MI: condex = n;
         COND_PL: condex = ~n;
         COND_VS: condex = v;
         COND_VC: condex = ~v;
         COND_HI: condex = c & ~z;
         COND_LS: condex = ~c | z;
         COND_GE: condex = (n == v);
         COND_LT: condex = (n != v);
         COND_GT: condex = ~z & (n == v);
         COND_LE: condex = z | (n != v);
         COND_AL: condex = 1'b1;
         default: condex = 1'b0;
      endcase
   end

   // Flags register: NZ and CV groups written independently, only when the condition passes
   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= 4'b0000;
      end else begin
         if (flagw[1] && condex) flags[3:2] <= aluflags[3:2];
         if (flagw[0] && condex) flags[1:0] <= aluflags[1:0];
      end
   end

   // A completed fetch always advances the PC; everything else respects the condition
   assign pcwrite  = fetch_done | ((pcs | pcwb) & condex);
   assign regwrite = regw & condex;
   assign memwrite = memw & condex;

endmodule

// File: rtl/mc_controller_ws.sv
// Multicycle ARM control unit: main FSM, ALU decoder and condition logic, with bus wait states.
// Latency: LDR 5, STR 4, DP 4, B/BL 3 cycles; each MemReady=0 cycle adds one to its memory state.
// Backpressure: FETCH, MEMRD and MEMWR hold with MemReq=1 until MemReady=1; no other state stalls.
module mc_controller_ws
   import mc_ctrl_pkg::*;
#(
   parameter int ALUCTRL_W  = 2,
   parameter bit SUPPORT_BL = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [19:0]          Instr,
   input  logic [3:0]           ALUFlags,
   input  logic                 MemReady,
   output logic                 MemReq,
   output logic                 PCWrite,
   output logic                 MemWrite,
   output logic                 RegWrite,
   output logic                 IRWrite,
   output logic                 AdrSrc,
   output logic [1:0]           RegSrc,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ImmSrc,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 LinkSel
);

   // Instr carries bits [31:12]; field offsets below are relative to bit 12
   logic [3:0] cond;
   logic [1:0] op;
   logic       ibit;
   logic [3:0] cmd;
   logic       sbit;     // S for data processing, L for memory
   logic       link;     // Instr[24] in branches
   logic [3:0] rd;
   logic       unused_rn;

   assign cond      = Instr[19:16];
   assign op        = Instr[15:14];
   assign ibit      = Instr[13];
   assign cmd       = Instr[12:9];
   assign sbit      = Instr[8];
   assign link      = Instr[12];
   assign rd        = Instr[3:0];
   assign unused_rn = ^Instr[7:4];

   state_t     state, state_nxt;
   logic [2:0] dp_op, alu_op;
   logic       dp_valid, dp_nowrite, dp_regw;
   logic [1:0] dp_flagw, flagw;
   logic       regw, memw, pcs, pcwb, fetch_done;

   // ALU decoder: unsupported cmds become a flag-preserving, non-writing NOP
   always_comb begin
      dp_op      = ALU_ADD;
      dp_valid   = 1'b1;
      dp_nowrite = 1'b0;
      case (cmd)
         CMD_ADD: dp_op = ALU_ADD;
         CMD_SUB: dp_op = ALU_SUB;
         CMD_AND: dp_op = ALU_AND;
         CMD_ORR: dp_op = ALU_ORR;
         CMD_EOR: begin
            if (ALUCTRL_W >= 3) dp_op = ALU_EOR;
            else                dp_valid = 1'b0;
         end
         CMD_CMP: begin
            dp_op      = ALU_SUB;
            dp_nowrite = 1'b1;
         end
         CMD_TST: begin
            dp_op      = ALU_AND;
            dp_nowrite = 1'b1;
         end
         default: dp_valid = 1'b0;
      endcase
      if (!dp_valid) dp_op = ALU_ADD;
      dp_regw     = dp_valid & ~dp_nowrite;
      dp_flagw[1] = dp_valid & sbit;
      dp_flagw[0] = dp_valid & sbit &
                    ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nxt;
   end

   // Next-state and per-state control; reset masks every enable so nothing fires mid-reset
   always_comb begin
      state_nxt  = state;
      MemReq     = 1'b0;
      IRWrite    = 1'b0;
      fetch_done = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_REG;
      ResultSrc  = RES_ALUOUT;
      alu_op     = ALU_ADD;
      regw       = 1'b0;
      memw       = 1'b0;
      pcs        = 1'b0;
      pcwb       = 1'b0;
      flagw      = 2'b00;
      LinkSel    = 1'b0;
      case (state)
         S_FETCH: begin
            MemReq    = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            if (MemReady) begin
               IRWrite    = 1'b1;
               fetch_done = 1'b1;
               state_nxt  = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_FOUR;
            case (op)
               OP_MEM:  state_nxt = S_MEMADR;
               OP_DP:   state_nxt = ibit ? S_EXECUTEI : S_EXECUTER;
               OP_BR:   state_nxt = S_BRANCH;
               default: state_nxt = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ALUSrcB   = SRCB_IMM;
            state_nxt = sbit ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            MemReq = 1'b1;
            AdrSrc = 1'b1;
            if (MemReady) state_nxt = S_MEMWB;
         end
         S_MEMWR: begin
            MemReq = 1'b1;
            AdrSrc = 1'b1;
            memw   = 1'b1;
            if (MemReady) state_nxt = S_FETCH;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            regw      = 1'b1;
            pcwb      = (rd == 4'hF);
            state_nxt = S_FETCH;
         end
         S_EXECUTER, S_EXECUTEI: begin
            ALUSrcB   = (state == S_EXECUTEI) ? SRCB_IMM : SRCB_REG;
            alu_op    = dp_op;
            flagw     = dp_flagw;
            state_nxt = S_ALUWB;
         end
         S_ALUWB: begin
            ResultSrc = RES_ALUOUT;
            regw      = dp_regw;
            pcwb      = dp_regw & (rd == 4'hF);
            state_nxt = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALURESULT;
            pcs       = 1'b1;
            if (SUPPORT_BL && link) begin
               ResultSrc = RES_PC;
               regw      = 1'b1;
               LinkSel   = 1'b1;
            end
            state_nxt = S_FETCH;
         end
         default: state_nxt = S_FETCH;
      endcase
      if (reset) begin
         MemReq     = 1'b0;
         IRWrite    = 1'b0;
         fetch_done = 1'b0;
         regw       = 1'b0;
         memw       = 1'b0;
         pcs        = 1'b0;
         pcwb       = 1'b0;
         flagw      = 2'b00;
         LinkSel    = 1'b0;
      end
   end

   assign ALUControl = ALUCTRL_W'(alu_op);
   assign ImmSrc     = op;
   assign RegSrc     = {(op == OP_MEM) & ~sbit, (op == OP_BR)};

   mc_condlogic u_condlogic (
      .clk        (clk),
      .reset      (reset),
      .cond       (cond),
      .aluflags   (ALUFlags),
      .flagw      (flagw),
      .regw       (regw),
      .memw       (memw),
      .pcs        (pcs),
      .fetch_done (fetch_done),
      .pcwb       (pcwb),
      .pcwrite    (PCWrite),
      .regwrite   (RegWrite),
      .memwrite   (MemWrite)
   );

endmodule

// File: tb/tb_mc_controller_ws.sv
// Directed bench for mc_controller_ws: two instances (EOR+BL build, and 2-bit ALU without BL).
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
// Enable vectors are {MemReq, IRWrite, PCWrite, RegWrite, MemWrite, LinkSel}.
module tb_mc_controller_ws;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        MemReady;

   logic       a_memreq, a_pcwrite, a_memwrite, a_regwrite, a_irwrite, a_adrsrc, a_alusrca, a_linksel;
   logic [1:0] a_regsrc, a_alusrcb, a_resultsrc, a_immsrc;
   logic [2:0] a_aluctl;
   logic       b_memreq, b_pcwrite, b_memwrite, b_regwrite, b_irwrite, b_adrsrc, b_alusrca, b_linksel;
   logic [1:0] b_regsrc, b_alusrcb, b_resultsrc, b_immsrc;
   logic [1:0] b_aluctl;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   wire [5:0] a_en = {a_memreq, a_irwrite, a_pcwrite, a_regwrite, a_memwrite, a_linksel};
   wire [5:0] b_en = {b_memreq, b_irwrite, b_pcwrite, b_regwrite, b_memwrite, b_linksel};

   mc_controller_ws #(.ALUCTRL_W(3), .SUPPORT_BL(1'b1)) dut_a (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
      .MemReq(a_memreq), .PCWrite(a_pcwrite), .MemWrite(a_memwrite), .RegWrite(a_regwrite),
      .IRWrite(a_irwrite), .AdrSrc(a_adrsrc), .RegSrc(a_regsrc), .ALUSrcA(a_alusrca),
      .ALUSrcB(a_alusrcb), .ResultSrc(a_resultsrc), .ImmSrc(a_immsrc),
      .ALUControl(a_aluctl), .LinkSel(a_linksel)
   );

   mc_controller_ws #(.ALUCTRL_W(2), .SUPPORT_BL(1'b0)) dut_b (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
      .MemReq(b_memreq), .PCWrite(b_pcwrite), .MemWrite(b_memwrite), .RegWrite(b_regwrite),
      .IRWrite(b_irwrite), .AdrSrc(b_adrsrc), .RegSrc(b_regsrc), .ALUSrcA(b_alusrca),
      .ALUSrcB(b_alusrcb), .ResultSrc(b_resultsrc), .ImmSrc(b_immsrc),
      .ALUControl(b_aluctl), .LinkSel(b_linksel)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; MemReady = 1'b0; Instr = 20'hEC000; ALUFlags = 4'h0;
      tick;
      reset = 1'b0; #1;
      tests++;
      if ({a_en, b_en} !== {6'b100000, 6'b100000})
         $display("FAIL reset_fetch_wait: got %b/%b expected 100000/100000", a_en, b_en);
      tick;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         MemReady = (i == 2); #1;
         tests++;
         if ({a_en, b_en} !== 12'b0) begin
            fails++;
            $display("FAIL reset_hold_%0d: got %b/%b expected 000000/000000", i, a_en, b_en);
         end
         tick;
      end
      reset = 1'b0; MemReady = 1'b1; #1;
      tests++;
      if ({a_en, b_en, a_adrsrc, a_alusrca, a_alusrcb, a_resultsrc} !== {12'b111000_111000, 6'b011010}) begin
         fails++;
         $display("FAIL reset_first_fetch: got %b/%b sel %b%b%b%b expected 111000/111000 sel 011010",
                  a_en, b_en, a_adrsrc, a_alusrca, a_alusrcb, a_resultsrc);
      end
      tick;
      MemReady = 1'b0; #1;
      tests++;
      if ({a_en, b_en, a_alusrca, a_alusrcb} !== {12'b0, 3'b110}) begin
         fails++;
         $display("FAIL reset_decode: got %b/%b srca %b srcb %b expected 0/0 1 10",
                  a_en, b_en, a_alusrca, a_alusrcb);
      end
      tick;
      #1;
      tests++;
      if ({a_en, b_en} !== {6'b100000, 6'b100000}) begin
         fails++;
         $display("FAIL undef_back_to_fetch: got %b/%b expected 100000/100000", a_en, b_en);
      end
      tick;
   endtask

   task automatic test_adds;
      Instr = 20'hE2921; MemReady = 1'b1; ALUFlags = 4'hF; #1;
      tests++;
      if ({a_en, b_en} !== {6'b111000, 6'b111000}) begin
         fails++;
         $display("FAIL adds_fetch: got %b/%b expected 111000/111000", a_en, b_en);
      end
      tick;
      MemReady = 1'b0;
      tick;
      ALUFlags = 4'b0011; #1;
      tests++;
      if ({a_en, b_en, a_alusrca, a_alusrcb, a_aluctl, b_aluctl} !== {12'b0, 3'b001, 3'd0, 2'd0}) begin
         fails++;
         $display("FAIL adds_execi: got %b/%b srca %b srcb %b alu %b/%b expected 0/0 0 01 000/00",
                  a_en, b_en, a_alusrca, a_alusrcb, a_aluctl, b_aluctl);
      end
      tick;
      ALUFlags = 4'hF; #1;
      tests++;
      if ({a_en, b_en, a_resultsrc} !== {6'b000100, 6'b000100, 2'b00}) begin
         fails++;
         $display("FAIL adds_aluwb: got %b/%b res %b expected 000100/000100 res 00", a_en, b_en, a_resultsrc);
      end
      tick;
      ALUFlags = 4'h0;
   endtask

   task automatic test_branch(input logic [19:0] instr, input logic [5:0] exp_a, input logic [5:0] exp_b,
                              input logic [3:0] exp_res, input string name);
      Instr = instr; MemReady = 1'b1;
      tick;
      MemReady = 1'b0;
      tick;
      #1;
      tests++;
      if ({a_en, b_en, a_resultsrc, b_resultsrc, a_regsrc[0]} !== {exp_a, exp_b, exp_res, 1'b1}) begin
         fails++;
         $display("FAIL %s: got %b/%b res %b/%b regsrc0 %b expected %b/%b res %b/%b regsrc0 1",
                  name, a_en, b_en, a_resultsrc, b_resultsrc, a_regsrc[0],
                  exp_a, exp_b, exp_res[3:2], exp_res[1:0]);
      end
      tick;
   endtask

   task automatic test_alu_decode;
      logic [3:0] cmds [8]  = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1000, 4'b1101, 4'b0100};
      logic [3:0] rds  [8]  = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd15};
      logic [2:0] alus [8]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd0, 3'd0};
      logic [5:0] wbs  [8]  = '{6'b000100, 6'b000100, 6'b000100, 6'b000100,
                                6'b000000, 6'b000000, 6'b000000, 6'b001100};
      for (int k = 0; k < 8; k++) begin
         Instr = {4'hE, 2'b00, 1'b0, cmds[k], 1'b0, 4'h2, rds[k]}; MemReady = 1'b1;
         tick;
         MemReady = 1'b0;
         tick;
         #1;
         tests++;
         if ({a_aluctl, b_aluctl, a_alusrcb} !== {alus[k], alus[k][1:0], 2'b00}) begin
            fails++;
            $display("FAIL alu_dec_%0d: got alu %b/%b srcb %b expected %b/%b srcb 00",
                     k, a_aluctl, b_aluctl, a_alusrcb, alus[k], alus[k][1:0]);
         end
         tick;
         #1;
         tests++;
         if ({a_en, b_en} !== {wbs[k], wbs[k]}) begin
            fails++;
            $display("FAIL alu_wb_%0d: got %b/%b expected %b/%b", k, a_en, b_en, wbs[k], wbs[k]);
         end
         tick;
      end
   endtask

   task automatic test_cmp_z;
      Instr = 20'hE3510; MemReady = 1'b1;
      tick;
      MemReady = 1'b0;
      tick;
      ALUFlags = 4'b0100; #1;
      tests++;
      if ({a_aluctl, b_aluctl} !== {3'd1, 2'd1}) begin
         fails++;
         $display("FAIL cmp_exec: got alu %b/%b expected 001/01", a_aluctl, b_aluctl);
      end
      tick;
      ALUFlags = 4'b0000; #1;
      tests++;
      if ({a_en, b_en} !== 12'b0) begin
         fails++;
         $display("FAIL cmp_nowrite: got %b/%b expected 000000/000000", a_en, b_en);
      end
      tick;
   endtask

   task automatic test_store;
      // STRNE with Z=1: transfer still happens, write suppressed, wait state honoured
      Instr = 20'h15812; MemReady = 1'b1;
      tick;
      MemReady = 1'b0;
      tick;
      #1;
      tests++;
      if ({a_en, a_alusrcb, a_regsrc} !== {6'b0, 2'b01, 2'b10}) begin
         fails++;
         $display("FAIL strne_memadr: got %b srcb %b regsrc %b expected 000000 01 10", a_en, a_alusrcb, a_regsrc);
      end
      tick;
      for (int i = 0; i < 2; i++) begin
         MemReady = (i == 1); #1;
         tests++;
         if ({a_en, b_en, a_adrsrc} !== {6'b100000, 6'b100000, 1'b1}) begin
            fails++;
            $display("FAIL strne_memwr_%0d: got %b/%b adr %b expected 100000/100000 adr 1", i, a_en, b_en, a_adrsrc);
         end
         tick;
      end
      MemReady = 1'b0; #1;
      tests++;
      if ({a_en, a_adrsrc} !== {6'b100000, 1'b0}) begin
         fails++;
         $display("FAIL strne_refetch: got %b adr %b expected 100000 adr 0", a_en, a_adrsrc);
      end
      // STREQ with Z=1 writes
      Instr = 20'h05812; MemReady = 1'b1;
      tick;
      MemReady = 1'b0;
      tick;
      tick;
      MemReady = 1'b1; #1;
      tests++;
      if ({a_en, b_en} !== {6'b100010, 6'b100010}) begin
         fails++;
         $display("FAIL streq_memwr: got %b/%b expected 100010/100010", a_en, b_en);
      end
      tick;
      MemReady = 1'b0;
   endtask

   task automatic test_ldr_waits;
      logic       rdy  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [5:0] exp  [9] = '{6'b100000, 6'b100000, 6'b111000, 6'b000000, 6'b000000,
                               6'b100000, 6'b100000, 6'b100000, 6'b000100};
      logic       adr  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      int ir_pulses = 0;
      int req_cycles = 0;
      Instr = 20'hE5912;
      for (int i = 0; i < 9; i++) begin
         MemReady = rdy[i]; #1;
         ir_pulses  += a_irwrite;
         req_cycles += a_memreq;
         tests++;
         if ({a_en, b_en, a_adrsrc} !== {exp[i], exp[i], adr[i]}) begin
            fails++;
            $display("FAIL ldr_cycle_%0d: got %b/%b adr %b expected %b/%b adr %b",
                     i, a_en, b_en, a_adrsrc, exp[i], exp[i], adr[i]);
         end
         tick;
      end
      MemReady = 1'b0; #1;
      tests++;
      if ({a_memreq, a_adrsrc, ir_pulses, req_cycles} !== {1'b1, 1'b0, 32'd1, 32'd6}) begin
         fails++;
         $display("FAIL ldr_total: got req %b adr %b irpulses %0d reqcycles %0d expected 1 0 1 6",
                  a_memreq, a_adrsrc, ir_pulses, req_cycles);
      end
      tick;
   endtask

   task automatic test_eor;
      Instr = 20'hE0321; MemReady = 1'b1;
      tick;
      MemReady = 1'b0;
      tick;
      ALUFlags = 4'b1000; #1;
      tests++;
      if ({a_aluctl, b_aluctl} !== {3'b100, 2'b00}) begin
         fails++;
         $display("FAIL eor_exec: got alu %b/%b expected 100/00", a_aluctl, b_aluctl);
      end
      tick;
      ALUFlags = 4'b0000; #1;
      tests++;
      if ({a_en, b_en} !== {6'b000100, 6'b000000}) begin
         fails++;
         $display("FAIL eor_wb: got %b/%b expected 000100/000000", a_en, b_en);
      end
      tick;
      // Flags now: A = N only; B unchanged from CMP (Z only)
      test_branch({4'h4, 4'hA, 12'h0}, 6'b001000, 6'b000000, 4'b1010, "eor_flags_mi");
      test_branch({4'h0, 4'hA, 12'h0}, 6'b000000, 6'b001000, 4'b1010, "eor_flags_eq");
   endtask

   initial begin
      test_reset;
      test_adds;
      // Flags after ADDS are NZCV=0011 in both builds
      test_branch({4'h6, 4'hA, 12'h0}, 6'b001000, 6'b001000, 4'b1010, "b_vs");
      test_branch({4'h4, 4'hA, 12'h0}, 6'b000000, 6'b000000, 4'b1010, "b_mi");
      test_branch({4'h8, 4'hA, 12'h0}, 6'b001000, 6'b001000, 4'b1010, "b_hi");
      test_branch({4'h0, 4'hA, 12'h0}, 6'b000000, 6'b000000, 4'b1010, "b_eq");
      test_branch({4'hA, 4'hA, 12'h0}, 6'b000000, 6'b000000, 4'b1010, "b_ge");
      test_branch({4'hB, 4'hA, 12'h0}, 6'b001000, 6'b001000, 4'b1010, "b_lt");
      test_branch({4'hF, 4'hA, 12'h0}, 6'b000000, 6'b000000, 4'b1010, "b_nv");
      test_alu_decode;
      test_cmp_z;
      test_store;
      test_ldr_waits;
      test_branch({4'hE, 4'hB, 12'h0}, 6'b001101, 6'b001000, 4'b1110, "bl");
      test_eor;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
